cla_wide_add_sequencer: RTL and testbench
=========================================

// Module: cla_wide_add_sequencer
// PURPOSE
//  Sequences one external 4-bit carry_look_ahead_adder slice over WIDTH-bit operands, one nibble per cycle.
//  Carry is registered between nibbles, from LSB to MSB.
//  Sits between a valid/ready producer and a valid/ready consumer, so wide adds reuse one CLA slice.
// PARAMETERS
//  WIDTH   16   operand/sum width; multiple of 4, >= 4
//  NSLICE  WIDTH/4 (localparam)   nibble passes per add
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to bit 0
//  slice_a    out  4      to CLA slice .A
//  slice_b    out  4      to CLA slice .B
//  slice_cin  out  1      to CLA slice .Cin
//  slice_out  in   5      from CLA slice .Out ({cout,sum[3:0]}, combinational)
//  busy       out  1      high in RUN
//  out_valid  out  1      result valid (DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out of bit WIDTH-1
// BEHAVIOUR
//  FSM states:
//   - IDLE: in_ready=1. On in_valid: latch a, b; carry_reg<=cin; idx<=0; go to RUN.
//   - RUN: slice_a=a_reg[4*idx+:4], slice_b=b_reg[4*idx+:4], slice_cin=carry_reg.
//     Each edge: sum_reg[4*idx+:4]<=slice_out[3:0]; carry_reg<=slice_out[4]; idx<=idx+1.
//     On idx==NSLICE-1, go to DONE instead of incrementing.
//   - DONE: out_valid=1; sum/cout held stable. On out_ready, go to IDLE.
//  Latency: accept edge + NSLICE edges -> out_valid. WIDTH=16: 4 cycles; WIDTH=4: 1 cycle.
//  Throughput: one add per NSLICE+2 cycles; no accept while RUN or DONE.
//  Outputs outside RUN: slice_a=0, slice_b=0, slice_cin=0.
//  cout=carry_reg after the final nibble.
//  Reset (any state, incl. mid-RUN):
//   - state=IDLE, idx=0, sum_reg=0, carry_reg=0.
//   - out_valid=0, busy=0, in_ready=1 the cycle after rst deasserts; partial result discarded.
//  in_valid while not IDLE: ignored; the producer must hold.
//  out_ready while not DONE: ignored.
//  A new add overwrites sum_reg nibble by nibble. sum is only meaningful while out_valid=1.
// CONFIGURATION
//  CLA_SEQ_OVF_EN defined:
//   - adds output port ovf (1 bit): signed overflow, valid with out_valid.
//   - ovf=(a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]).
//   - ovf resets to 0.
//  CLA_SEQ_OVF_EN undefined: ovf port and logic are absent; all other behaviour is identical.
// TESTING (WIDTH=16, slice = carry_look_ahead_adder)
//  1. 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0; out_valid exactly 4 cycles after accept.
//  2. 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1; carry ripples through all 4 nibbles.
//  3. 0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1; then 0x0003+0x0002, cin=1 -> sum=0x0006, cout=0.
//  4. out_ready low 3 cycles in DONE -> sum/cout/out_valid held; in_ready=0; new in_valid ignored.
//  5. rst pulse at idx=2 of RUN -> next cycle IDLE, in_ready=1, out_valid=0.
//     Following 0x0101+0x0202, cin=0 -> sum=0x0303.
//  6. CLA_SEQ_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1; 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.

Source files
------------

// File: rtl/cla_wide_add_sequencer.sv
// Runs one external 4-bit CLA slice over WIDTH-bit operands, one nibble per cycle, from LSB to MSB.
// Optional feature macro: CLA_SEQ_OVF_EN adds a signed-overflow output ovf.
module cla_wide_add_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [4:0]       slice_out,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_SEQ_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic             w_run;

  assign w_run = (r_state == ST_RUN);

  // Nibble select as a decoded mux keeps every part-select constant.
  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int i = 0; i < int'(NSLICE); i++) begin
      if (r_idx == IDXW'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  assign slice_a   = w_run ? w_nib_a : 4'h0;
  assign slice_b   = w_run ? w_nib_b : 4'h0;
  assign slice_cin = w_run ? r_carry : 1'b0;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = w_run;
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_carry;

`ifdef CLA_SEQ_OVF_EN
  assign ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < int'(NSLICE); i++) begin
            if (r_idx == IDXW'(i)) begin
              r_sum[4*i +: 4] <= slice_out[3:0];
            end
          end
          r_carry <= slice_out[4];
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_wide_add_sequencer.sv
// Bench for cla_wide_add_sequencer (WIDTH=16) with a behavioural 4-bit slice and a plain-arithmetic
// reference model; define CLA_SEQ_OVF_EN to also check ovf.
module tb_cla_wide_add_sequencer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [4:0]   slice_out;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External CLA slice stand-in: a 4-bit adder with carry-out.
  assign slice_out = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  cla_wide_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_cin (slice_cin),
    .slice_out (slice_out),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_SEQ_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; stall holds out_ready low in DONE, poke offers new operands meanwhile.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input int stall, input bit poke);
    logic [W:0] ref_full;
    logic [W-1:0] ref_sum;
    logic ref_cout;
    int k;
    ref_full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tcin};
    ref_sum  = ref_full[W-1:0];
    ref_cout = ref_full[W];
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check_eq("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a = ta;
    b = tb_v;
    cin = tcin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    check_eq("busy_after_accept", {31'b0, busy}, 32'd1);
    check_eq("in_ready_in_run", {31'b0, in_ready}, 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check_eq("latency", k, 32'd4);
    check_eq("sum", {16'b0, sum}, {16'b0, ref_sum});
    check_eq("cout", {31'b0, cout}, {31'b0, ref_cout});
`ifdef CLA_SEQ_OVF_EN
    check_eq("ovf", {31'b0, ovf},
             {31'b0, (ta[W-1] == tb_v[W-1]) && (ref_sum[W-1] != ta[W-1])});
`endif
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b1;
      end
      tick();
      check_eq("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("hold_sum", {16'b0, sum}, {16'b0, ref_sum});
      check_eq("hold_cout", {31'b0, cout}, {31'b0, ref_cout});
      check_eq("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("idle_after_release", {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = 16'hBEEF;
    b = 16'h1234;
    cin = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_sum", {16'b0, sum}, 32'd0);
    check_eq("rst_cout", {31'b0, cout}, 32'd0);
    check_eq("idle_slice_zero", {23'b0, slice_a, slice_b, slice_cin}, 32'd0);
    // out_ready outside DONE must not matter
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("out_ready_idle_ignored", {31'b0, in_ready}, 32'd1);

    do_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    do_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_add(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    do_add(16'h0003, 16'h0002, 1'b1, 0, 1'b0);
    do_add(16'h1357, 16'h2468, 1'b0, 3, 1'b1);
`ifdef CLA_SEQ_OVF_EN
    do_add(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    do_add(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
`endif

    // Reset in the middle of RUN, at nibble index 2
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_run_busy", {31'b0, busy}, 32'd1);
    check_eq("mid_run_slice_a", {28'b0, slice_a}, 32'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("post_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("post_rst_sum", {16'b0, sum}, 32'd0);
    do_add(16'h0101, 16'h0202, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 7 == 0) ra = 16'hFFFF;
      do_add(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
